// File: rtl/instruction_fetch.sv
// Fetch unit for a byte-wide memory: reads two bytes per 16-bit instruction (big-endian)
// and hands each instruction to decode over a valid/ready handshake.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    input  logic              bus_busy,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;

    logic              fetching;

    assign fetching = (state_q == FETCH_HI) || (state_q == FETCH_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_HI;
            pc_q          <= ADDR_W'(RESET_PC);
            hi_byte_q     <= 8'h00;
            instr_q       <= 16'h0000;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hi_byte_q     <= hi_byte_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Bus is released while the load/store path owns it and whenever an instruction is held.
    always_comb begin
        mem_we   = 1'b0;
        mem_cs   = 1'b0;
        mem_addr = '0;
        if (!rst) begin
            mem_cs = fetching && !bus_busy;
            if (state_q == FETCH_HI) begin
                mem_addr = pc_q;
            end else if (state_q == FETCH_LO) begin
                mem_addr = pc_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hi_byte_d     = hi_byte_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        // Redirect wins over stalls and over a handshake in the same cycle.
        if (redirect) begin
            pc_d          = redirect_addr;
            state_d       = FETCH_HI;
            instr_valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH_HI: begin
                    if (!bus_busy) begin
                        hi_byte_d = mem_rdata;
                        state_d   = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (!bus_busy) begin
                        instr_d       = {hi_byte_q, mem_rdata};
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + ADDR_W'(2);
                        state_d       = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = FETCH_HI;
                    end
                end
                default: state_d = FETCH_HI;
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural byte memory.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic        bus_busy;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [7:0]  mem [0:65535];

    int tests_run = 0;
    int tests_failed = 0;

    instruction_fetch #(.RESET_PC(16'h0000), .ADDR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_cs        (mem_cs),
        .mem_we        (mem_we),
        .bus_busy      (bus_busy),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    // Deselected memory returns a marker byte so a capture without chip select shows up.
    assign mem_rdata = mem_cs ? mem[mem_addr] : 8'hEE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic cs, input logic [15:0] addr);
        #1;
        chk({tag, ".cs"}, 32'(mem_cs), 32'(cs));
        if (cs) chk({tag, ".addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, ".we"}, 32'(mem_we), 32'd0);
    endtask

    task automatic chk_instr(input string tag, input logic [15:0] ins, input logic [15:0] pc);
        #1;
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".instr"}, 32'(instr), 32'(ins));
        chk({tag, ".pc"}, 32'(instr_pc), 32'(pc));
        chk({tag, ".cs"}, 32'(mem_cs), 32'd0);
        $display("[TB] %s instr=%h pc=%h", tag, instr, instr_pc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[0] = 8'h08; mem[1] = 8'h60; mem[2] = 8'h08;
        mem[3] = 8'h48; mem[4] = 8'h00; mem[5] = 8'h02;
        rst = 1'b1; bus_busy = 1'b0; redirect = 1'b0;
        redirect_addr = 16'h0000; instr_ready = 1'b1;
        cyc(); cyc();

        // Reset state
        #1;
        chk("rst.cs", 32'(mem_cs), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.instr", 32'(instr), 32'd0);
        chk("rst.pc", 32'(instr_pc), 32'd0);
        rst = 1'b0;

        // Basic stream: valid on cycles 2, 5, 8 after release
        chk_bus("basic.c0", 1'b1, 16'h0000);
        chk("basic.c0.valid", 32'(instr_valid), 32'd0);
        cyc(); chk_bus("basic.c1", 1'b1, 16'h0001);
        cyc(); chk_instr("basic.i0", 16'h0860, 16'h0000);
        cyc(); chk_bus("basic.c3", 1'b1, 16'h0002);
        chk("basic.c3.valid", 32'(instr_valid), 32'd0);
        cyc(); chk_bus("basic.c4", 1'b1, 16'h0003);
        cyc(); chk_instr("basic.i1", 16'h0848, 16'h0002);
        cyc(); chk_bus("basic.c6", 1'b1, 16'h0004);
        cyc(); chk_bus("basic.c7", 1'b1, 16'h0005);
        cyc(); chk_instr("basic.i2", 16'h0002, 16'h0004);

        // Backpressure: ready low for 10 cycles
        do_reset();
        instr_ready = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 10; i++) begin
            chk_instr($sformatf("bp.hold%0d", i), 16'h0860, 16'h0000);
            cyc();
        end
        instr_ready = 1'b1;
        chk_instr("bp.accept", 16'h0860, 16'h0000);
        cyc(); chk_bus("bp.next_hi", 1'b1, 16'h0002);
        cyc(); cyc(); chk_instr("bp.next", 16'h0848, 16'h0002);

        // Bus stall during FETCH_LO of pc=2
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        chk_bus("stall.pre", 1'b1, 16'h0003);
        bus_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_bus($sformatf("stall.busy%0d", i), 1'b0, 16'h0000);
            chk($sformatf("stall.busy%0d.valid", i), 32'(instr_valid), 32'd0);
            cyc();
        end
        bus_busy = 1'b0;
        chk_bus("stall.resume", 1'b1, 16'h0003);
        cyc(); chk_instr("stall.instr", 16'h0848, 16'h0002);

        // Redirect during FETCH_LO of pc=0
        do_reset();
        cyc();
        redirect = 1'b1; redirect_addr = 16'h0004;
        cyc();
        redirect = 1'b0;
        chk_bus("redir.lo.hi", 1'b1, 16'h0004);
        chk("redir.lo.valid", 32'(instr_valid), 32'd0);
        cyc(); cyc(); chk_instr("redir.lo.instr", 16'h0002, 16'h0004);

        // Redirect in HOLD together with ready: no transfer, refetch from 4
        redirect = 1'b1; redirect_addr = 16'h0004; instr_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        chk_bus("redir.hold.hi", 1'b1, 16'h0004);
        chk("redir.hold.valid", 32'(instr_valid), 32'd0);
        cyc(); chk_bus("redir.hold.lo", 1'b1, 16'h0005);
        cyc(); chk_instr("redir.hold.instr", 16'h0002, 16'h0004);

        // Odd redirect target
        redirect = 1'b1; redirect_addr = 16'h0001;
        cyc();
        redirect = 1'b0;
        cyc(); cyc(); chk_instr("redir.odd", 16'h6008, 16'h0001);

        // Mid-operation reset while in FETCH_LO, then in HOLD
        do_reset();
        cyc();
        rst = 1'b1;
        chk_bus("midrst.lo", 1'b0, 16'h0000);
        chk("midrst.lo.addr", 32'(mem_addr), 32'd0);
        cyc();
        chk("midrst.lo.valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        chk_bus("midrst.restart", 1'b1, 16'h0000);
        cyc(); cyc(); chk_instr("midrst.first", 16'h0860, 16'h0000);
        instr_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst.hold.valid", 32'(instr_valid), 32'd0);
        chk_bus("midrst.hold.restart", 1'b1, 16'h0000);
        instr_ready = 1'b1;
        cyc(); cyc(); chk_instr("midrst.hold.first", 16'h0860, 16'h0000);

        // Wrap-around at FFFF
        mem[16'hFFFF] = 8'hAB; mem[0] = 8'hCD;
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        cyc();
        redirect = 1'b0;
        chk_bus("wrap.hi", 1'b1, 16'hFFFF);
        cyc(); chk_bus("wrap.lo", 1'b1, 16'h0000);
        cyc(); chk_instr("wrap.instr", 16'hABCD, 16'hFFFF);
        cyc(); chk_bus("wrap.next", 1'b1, 16'h0001);
        mem[0] = 8'h08;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream master of the byte-wide main memory. It sequences two 8-bit reads per 16-bit instruction and assembles them big-endian: the byte at PC is [15:8] and the byte at PC+1 is [7:0].
- It presents each instruction to decode over a valid/ready handshake.
- It supports branch redirect and yields the memory bus to the load/store path on request.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, memory address width; the PC is ADDR_W bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- mem_addr  output  ADDR_W  byte address to memory.
- mem_rdata  input  8  read data from memory; top level resolves the tri-state bus. Valid combinationally in the same cycle as mem_addr while mem_cs=1.
- mem_cs  output  1  memory chip select.
- mem_we  output  1  memory write enable; tied 0.
- bus_busy  input  1  load/store path owns the memory bus this cycle.
- redirect  input  1  one-cycle request to restart fetch at redirect_addr.
- redirect_addr  input  ADDR_W  new fetch address.
- instr  output  16  assembled instruction.
- instr_pc  output  ADDR_W  address of the instr high byte.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts the instruction.

Behaviour:
- States: FETCH_HI, FETCH_LO, HOLD. Registers: pc, hi_byte, instr, instr_pc, instr_valid.
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=FETCH_HI.
  - instr=16'h0000, instr_pc=0, instr_valid=0, hi_byte=0.
  - While rst=1: mem_cs=0, mem_addr=0.
  - rst has priority over every other input.
- Combinational bus outputs:
  - mem_we=0 always.
  - mem_cs=1 only when state is FETCH_HI or FETCH_LO and bus_busy=0 and rst=0.
  - mem_addr=pc in FETCH_HI, pc+1 (mod 2^ADDR_W) in FETCH_LO, 0 otherwise.
- FETCH_HI, bus_busy=0: on posedge, hi_byte<=mem_rdata, state->FETCH_LO.
- FETCH_LO, bus_busy=0: on posedge:
  - instr<={hi_byte, mem_rdata}, instr_pc<=pc, instr_valid<=1.
  - pc<=pc+2 (mod 2^ADDR_W).
  - state->HOLD.
- bus_busy=1 in FETCH_HI or FETCH_LO: no state change, no capture, mem_cs=0. A held-off partial fetch resumes with the same address when bus_busy falls.
- HOLD:
  - instr_valid=1; instr and instr_pc stable.
  - If instr_ready=1 at posedge: instr_valid<=0, state->FETCH_HI.
  - Otherwise hold indefinitely.
- Throughput: 3 cycles per instruction with no stalls. Latency from reset release to the first instr_valid is 2 cycles.
- Redirect (any state, rst=0) at posedge:
  - pc<=redirect_addr, state->FETCH_HI, instr_valid<=0.
  - Any partially fetched hi_byte is discarded.
  - Redirect overrides bus_busy and instr_ready in the same cycle. A simultaneous handshake in HOLD is not a valid transfer: decode must not consume an instruction in a redirect cycle.
- Wrap-around:
  - Instruction at PC=FFFF takes its high byte from FFFF and its low byte from 0000.
  - Next pc after it = 0001.
- Odd redirect_addr is legal; there is no alignment requirement.
- Mid-operation reset: any state returns to FETCH_HI with pc=RESET_PC on the next edge, and instr_valid drops.

Test Plan:
- Basic stream:
  - Stimulus: memory preloaded 00:08 01:60 02:08 03:48 04:00 05:02; instr_ready=1.
  - Response: instr 0x0860 @pc 0, 0x0848 @pc 2, 0x0002 @pc 4. instr_valid asserted on cycles 2, 5, 8 after reset release. mem_addr sequence 0,1,-,2,3,-,4,5.
- Backpressure:
  - Stimulus: instr_ready=0 for 10 cycles after the first valid.
  - Response: instr stays 0x0860, instr_valid=1, mem_cs=0 throughout. After ready rises, the next instruction is 0x0848 with no skip or duplicate.
- Bus stall:
  - Stimulus: bus_busy=1 for 4 cycles while in FETCH_LO of pc=2.
  - Response: mem_cs=0 for those cycles, state held. On release the read is from addr 3 and instr=0x0848.
- Redirect:
  - Stimulus: redirect=1, redirect_addr=0x0004 during FETCH_LO of pc=0.
  - Response: no 0x0860 delivered; next instr=0x0002 @instr_pc=4. Also repeat with redirect asserted in HOLD with instr_ready=1: no transfer, next instr from 0x0004.
- Wrap-around:
  - Stimulus: mem[FFFF]=0xAB, mem[0000]=0xCD, redirect to 0xFFFF.
  - Response: instr=0xABCD @instr_pc=FFFF, then a fetch from addr 0001.
- Reset mid-fetch:
  - Stimulus: rst=1 for one cycle while in FETCH_LO.
  - Response: instr_valid=0, mem_cs=0 during reset, then a restart at RESET_PC delivering 0x0860 first.
